// File: rtl/lc3_pkg.sv
// Shared LC3 decode definitions: opcodes, control encodings and the execute-control payload.
package lc3_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CTRL_E_W = 6;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned WB_W     = 2;

    typedef enum logic [OPC_W-1:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_OFF11 = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9  = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6  = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO  = 2'b11;

    localparam logic [WB_W-1:0] WB_ALU = 2'b00;
    localparam logic [WB_W-1:0] WB_MEM = 2'b01;
    localparam logic [WB_W-1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_control_t;

    // RTI and the reserved opcode have no implementation in this core.
    function automatic logic is_illegal_op(input opcode_e op);
        return (op == OP_RTI) || (op == OP_RES);
    endfunction

endpackage

// File: rtl/lc3_decode_logic.sv
// Combinational LC3 instruction decoder producing execute/writeback/memory controls.
// Optional macro LC3_DECODE_ILLEGAL_EN adds the o_illegal flag.
module lc3_decode_logic
    import lc3_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_ir11,
    input  logic             i_ir5,
    output e_control_t       o_e_ctrl,
    output logic [WB_W-1:0]  o_w_ctrl,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic             o_illegal,
`endif
    output logic             o_mem_ctrl
);

    opcode_e w_op;
    assign w_op = opcode_e'(i_opcode);

    always_comb begin
        o_e_ctrl   = '0;
        o_w_ctrl   = WB_ALU;
        o_mem_ctrl = 1'b0;
        case (w_op)
            OP_ADD: begin
                o_e_ctrl.alu_control = ALU_ADD;
                o_e_ctrl.op2select   = ~i_ir5;
            end
            OP_AND: begin
                o_e_ctrl.alu_control = ALU_AND;
                o_e_ctrl.op2select   = ~i_ir5;
            end
            OP_NOT: o_e_ctrl.alu_control = ALU_NOT;
            OP_LD, OP_LDI: begin
                o_e_ctrl.pcselect1 = PCSEL1_OFF9;
                o_e_ctrl.pcselect2 = 1'b1;
                o_w_ctrl           = WB_MEM;
                o_mem_ctrl         = (w_op == OP_LDI);
            end
            OP_LDR: begin
                o_e_ctrl.pcselect1 = PCSEL1_OFF6;
                o_w_ctrl           = WB_MEM;
            end
            OP_LEA: begin
                o_e_ctrl.pcselect1 = PCSEL1_OFF9;
                o_e_ctrl.pcselect2 = 1'b1;
                o_w_ctrl           = WB_PC;
            end
            OP_ST, OP_STI, OP_BR: begin
                o_e_ctrl.pcselect1 = PCSEL1_OFF9;
                o_e_ctrl.pcselect2 = 1'b1;
                o_mem_ctrl         = (w_op == OP_STI);
            end
            OP_STR: o_e_ctrl.pcselect1 = PCSEL1_OFF6;
            OP_JSR: begin
                // IR[11] selects JSR (npc + offset11) versus JSRR (base register).
                if (i_ir11) begin
                    o_e_ctrl.pcselect1 = PCSEL1_OFF11;
                    o_e_ctrl.pcselect2 = 1'b1;
                end else begin
                    o_e_ctrl.pcselect1 = PCSEL1_ZERO;
                end
            end
            OP_JMP: o_e_ctrl.pcselect1 = PCSEL1_ZERO;
            default: ;
        endcase
    end

`ifdef LC3_DECODE_ILLEGAL_EN
    assign o_illegal = is_illegal_op(w_op);
`endif

endmodule

// File: rtl/lc3_decode_stage.sv
// LC3 decode pipeline stage: registers the fetched word and npc, and the decoded controls.
// Optional macro LC3_DECODE_ILLEGAL_EN adds the registered illegal_op output.
module lc3_decode_stage
    import lc3_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_decode,
    input  logic                flush,
    input  logic [DATA_W-1:0]   instr_dout,
    input  logic [DATA_W-1:0]   npc_in,
    output logic [DATA_W-1:0]   ir,
    output logic [DATA_W-1:0]   npc_out,
    output logic [CTRL_E_W-1:0] e_control,
    output logic [WB_W-1:0]     w_control,
    output logic                mem_control,
`ifdef LC3_DECODE_ILLEGAL_EN
    output logic                illegal_op,
`endif
    output logic                dec_valid
);

    e_control_t          w_e_ctrl;
    logic [WB_W-1:0]     w_w_ctrl;
    logic                w_mem_ctrl;

    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_npc;
    e_control_t          r_e_ctrl;
    logic [WB_W-1:0]     r_w_ctrl;
    logic                r_mem_ctrl;
    logic                r_valid;

`ifdef LC3_DECODE_ILLEGAL_EN
    logic                w_illegal;
    logic                r_illegal;
`endif

    lc3_decode_logic u_decode (
        .i_opcode   (instr_dout[15:12]),
        .i_ir11     (instr_dout[11]),
        .i_ir5      (instr_dout[5]),
        .o_e_ctrl   (w_e_ctrl),
        .o_w_ctrl   (w_w_ctrl),
`ifdef LC3_DECODE_ILLEGAL_EN
        .o_illegal  (w_illegal),
`endif
        .o_mem_ctrl (w_mem_ctrl)
    );

    // Priority: reset > flush > capture > hold. Flush keeps ir/npc for debug visibility.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ir       <= '0;
            r_npc      <= '0;
            r_e_ctrl   <= '0;
            r_w_ctrl   <= '0;
            r_mem_ctrl <= 1'b0;
            r_valid    <= 1'b0;
`ifdef LC3_DECODE_ILLEGAL_EN
            r_illegal  <= 1'b0;
`endif
        end else if (flush) begin
            r_e_ctrl   <= '0;
            r_w_ctrl   <= '0;
            r_mem_ctrl <= 1'b0;
            r_valid    <= 1'b0;
`ifdef LC3_DECODE_ILLEGAL_EN
            r_illegal  <= 1'b0;
`endif
        end else if (enable_decode) begin
            r_ir       <= instr_dout;
            r_npc      <= npc_in;
            r_e_ctrl   <= w_e_ctrl;
            r_w_ctrl   <= w_w_ctrl;
            r_mem_ctrl <= w_mem_ctrl;
            r_valid    <= 1'b1;
`ifdef LC3_DECODE_ILLEGAL_EN
            r_illegal  <= w_illegal;
`endif
        end
    end

    assign ir          = r_ir;
    assign npc_out     = r_npc;
    assign e_control   = CTRL_E_W'(r_e_ctrl);
    assign w_control   = r_w_ctrl;
    assign mem_control = r_mem_ctrl;
    assign dec_valid   = r_valid;
`ifdef LC3_DECODE_ILLEGAL_EN
    assign illegal_op  = r_illegal;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Scoreboard bench for lc3_decode_stage: driver queues hand-computed expectations, monitor checks each cycle.
// Honors LC3_DECODE_ILLEGAL_EN when defined.
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_decode = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] instr_dout = '0;
    logic [15:0] npc_in = '0;
    logic [15:0] ir;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic        mem_control;
    logic        dec_valid;
`ifdef LC3_DECODE_ILLEGAL_EN
    logic        illegal_op;
`endif

    always #5 clock = ~clock;

    lc3_decode_stage dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enable_decode),
        .flush         (flush),
        .instr_dout    (instr_dout),
        .npc_in        (npc_in),
        .ir            (ir),
        .npc_out       (npc_out),
        .e_control     (e_control),
        .w_control     (w_control),
        .mem_control   (mem_control),
`ifdef LC3_DECODE_ILLEGAL_EN
        .illegal_op    (illegal_op),
`endif
        .dec_valid     (dec_valid)
    );

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        ill;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;

    // Architectural state of ir/npc/valid tracked by the bench; controls come from the vectors.
    logic [15:0] m_ir = '0;
    logic [15:0] m_npc = '0;
    logic        m_v = 1'b0;

    task automatic step(input logic rst, input logic fl, input logic en,
                        input logic [15:0] ins, input logic [15:0] npc,
                        input logic [5:0] ee, input logic [1:0] ew,
                        input logic em, input logic eill);
        exp_t x;
        @(negedge clock);
        reset = rst; flush = fl; enable_decode = en;
        instr_dout = ins; npc_in = npc;
        if (rst) begin
            m_ir = '0; m_npc = '0; m_v = 1'b0;
        end else if (fl) begin
            m_v = 1'b0;
        end else if (en) begin
            m_ir = ins; m_npc = npc; m_v = 1'b1;
        end
        x.ir = m_ir; x.npc = m_npc; x.e = ee; x.w = ew; x.m = em; x.ill = eill; x.v = m_v;
        exp_q.push_back(x);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge.
    always @(posedge clock) begin
        exp_t x;
        logic act_ill;
        #1;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            step_no++;
`ifdef LC3_DECODE_ILLEGAL_EN
            act_ill = illegal_op;
`else
            act_ill = 1'b0;
`endif
            n_checks++;
            if (ir === x.ir && npc_out === x.npc && e_control === x.e && w_control === x.w &&
                mem_control === x.m && act_ill === x.ill && dec_valid === x.v) begin
                n_pass++;
            end else begin
                $display("FAIL step%0d: got ir=%h npc=%h e=%b w=%0d mem=%b ill=%b v=%b, expected ir=%h npc=%h e=%b w=%0d mem=%b ill=%b v=%b",
                         step_no, ir, npc_out, e_control, w_control, mem_control, act_ill, dec_valid,
                         x.ir, x.npc, x.e, x.w, x.m, x.ill, x.v);
            end
        end
    end

    logic ill_on;

    initial begin
`ifdef LC3_DECODE_ILLEGAL_EN
        ill_on = 1'b1;
`else
        ill_on = 1'b0;
`endif
        //    rst  fl   en   instr     npc       e          w     m     ill
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b000000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h1283, 16'h3001, 6'b000001, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h1265, 16'h3002, 6'b000000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h927F, 16'h3003, 6'b100000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hA200, 16'h3004, 6'b000110, 2'd1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hE205, 16'h3005, 6'b000110, 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h6242, 16'h3006, 6'b001000, 2'd1, 1'b0, 1'b0);
        // Stall for five cycles with a changing instruction bus.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 16'h1283 + 16'(i), 16'h4000 + 16'(i), 6'b001000, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h3200, 16'h3010, 6'b000000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h3200, 16'h3011, 6'b000110, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hB000, 16'h3012, 6'b000110, 2'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'h1283, 16'h3013, 6'b000000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h4800, 16'h3020, 6'b000010, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h4080, 16'h3021, 6'b001100, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hC1C0, 16'h3022, 6'b001100, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h5020, 16'h3023, 6'b010000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h5002, 16'h3024, 6'b010001, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h2000, 16'h3025, 6'b000110, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h7000, 16'h3026, 6'b001000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0E01, 16'h3027, 6'b000110, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'hF025, 16'h3028, 6'b000000, 2'd0, 1'b0, 1'b0);
        // Reserved / RTI decode as NOP; flagged only when the illegal-op feature is built in.
        step(1'b0, 1'b0, 1'b1, 16'hD000, 16'h3030, 6'b000000, 2'd0, 1'b0, ill_on);
        step(1'b0, 1'b0, 1'b0, 16'h1283, 16'h3031, 6'b000000, 2'd0, 1'b0, ill_on);
        step(1'b0, 1'b0, 1'b1, 16'h1283, 16'h3032, 6'b000001, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h8000, 16'h3033, 6'b000000, 2'd0, 1'b0, ill_on);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 16'h3034, 6'b000000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h8000, 16'h3035, 6'b000000, 2'd0, 1'b0, ill_on);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b000000, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'b000000, 2'd0, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(negedge clock);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
